// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one side of a pipeline stage register.
// master drives valid/ctrl/data and receives ready; slave is the mirror image.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// One-cycle pipeline stage register with flush, stall counter and bubble-safe control.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_reg_if.slave      up,
  pipe_stage_reg_if.master     down,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  // State encodings equal the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1
`ifdef PIPE_STAGE_SKID_EN
    , SKID = 2'd2
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              accept, drain, load_main;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              load_skid, unload_skid;
  logic              ready_q;
`else
  logic              alive;
`endif

  assign accept = up.valid && up.ready;
  assign drain  = (state != EMPTY) && down.ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    state_nxt = state;
    load_main = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid   = 1'b0;
    unload_skid = 1'b0;
`endif
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt = FULL;
          load_main = 1'b1;
        end
        FULL: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (accept) begin
            state_nxt = SKID;
            load_skid = 1'b1;
          end
          end
        SKID: if (drain) begin
          state_nxt   = FULL;
          unload_skid = 1'b1;
`endif
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: datapath registers are reset too, so out_data reads zero while rst is low.
    if (!rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl <= '0;
      skid_data <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= state_nxt;
      if (load_main) begin
        main_ctrl <= up.ctrl;
        main_data <= up.data;
      end
`ifdef PIPE_STAGE_SKID_EN
      else if (unload_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= up.ctrl;
        skid_data <= up.data;
      end
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= (state_nxt != SKID);
  end
  assign up.ready = ready_q;
`else
  // Holds in_ready low until the first edge after reset releases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end
  assign up.ready = alive && (!down.valid || down.ready);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (down.valid && !down.ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Control is masked on bubbles so stale bits never look like a write or branch.
  assign down.valid = (state != EMPTY);
  assign down.ctrl  = down.valid ? main_ctrl : '0;
  assign down.data  = main_data;
  assign occupancy  = 2'(state);

endmodule
